// File: rtl/spu_arb_pkg.sv
// Shared types and the round-robin pick function used by the SPU arbiters.
package spu_arb_pkg;

    // Widest arbiter supported by the shared helpers.
    localparam int unsigned MAX_REQ   = 16;
    localparam int unsigned TAG_W_MAX = 4;

    // Requester index. Arbiters narrower than MAX_REQ use the low bits.
    typedef logic [TAG_W_MAX-1:0] tag_t;

    typedef struct packed {
        logic found;
        tag_t idx;
    } rr_pick_t;

    // Scan last+1, last+2, ... wrapping at num_req; the first set valid bit wins.
    function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                         input tag_t               last,
                                         input int unsigned        num_req);
        rr_pick_t    res;
        int unsigned idx;
        res = '0;
        for (int unsigned k = 1; k <= MAX_REQ; k++) begin
            if (k <= num_req && !res.found) begin
                idx = (32'(last) + k) % num_req;
                if (valid[idx[TAG_W_MAX-1:0]]) begin
                    res.found = 1'b1;
                    res.idx   = idx[TAG_W_MAX-1:0];
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/spu_data.sv
// Valid+tag delay line matching the subtractor depth so owner and result stay aligned.
module spu_data
    import spu_arb_pkg::*;
#(
    parameter int unsigned LATENCY  = 1,
    parameter int unsigned TAG_BITS = 2
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_cke,
    input  logic                i_valid,
    input  logic [TAG_BITS-1:0] i_tag,
    output logic                o_valid,
    output logic [TAG_BITS-1:0] o_tag,
    output logic                o_inflight
);

    generate
        if (LATENCY == 0) begin : g_comb
            logic w_unused;
            assign w_unused   = ^{i_clk, i_rst, i_cke};
            assign o_valid    = i_valid;
            assign o_tag      = i_tag;
            assign o_inflight = 1'b0;
        end else begin : g_pipe
            logic [LATENCY-1:0]  r_valid;
            logic [TAG_BITS-1:0] r_tag [LATENCY];

            // Shift valid/tag one stage per enabled cycle; reset drops everything in flight.
            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    r_valid <= '0;
                    for (int unsigned s = 0; s < LATENCY; s++) begin
                        r_tag[s] <= '0;
                    end
                end else if (i_cke) begin
                    r_valid[0] <= i_valid;
                    r_tag[0]   <= i_tag;
                    for (int unsigned s = 1; s < LATENCY; s++) begin
                        r_valid[s] <= r_valid[s-1];
                        r_tag[s]   <= r_tag[s-1];
                    end
                end
            end

            assign o_valid    = r_valid[LATENCY-1];
            assign o_tag      = r_tag[LATENCY-1];
            assign o_inflight = |r_valid;
        end
    endgenerate

endmodule

// File: rtl/spu_sub.sv
// Pipelined wrapping subtractor: o_diff = i_a - i_b after LATENCY enabled cycles.
module spu_sub
    import spu_arb_pkg::*;
#(
    parameter int unsigned LATENCY   = 1,
    parameter int unsigned DATA_BITS = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_cke,
    input  logic [DATA_BITS-1:0] i_a,
    input  logic [DATA_BITS-1:0] i_b,
    output logic [DATA_BITS-1:0] o_diff
);

    generate
        if (LATENCY == 0) begin : g_comb
            logic w_unused;
            assign w_unused = ^{i_clk, i_rst, i_cke};
            assign o_diff   = i_a - i_b;
        end else begin : g_pipe
            logic [DATA_BITS-1:0] r_pipe [LATENCY];

            // Difference enters stage 0 and shifts one stage per enabled cycle.
            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    for (int unsigned s = 0; s < LATENCY; s++) begin
                        r_pipe[s] <= '0;
                    end
                end else if (i_cke) begin
                    r_pipe[0] <= i_a - i_b;
                    for (int unsigned s = 1; s < LATENCY; s++) begin
                        r_pipe[s] <= r_pipe[s-1];
                    end
                end
            end

            assign o_diff = r_pipe[LATENCY-1];
        end
    endgenerate

endmodule

// File: rtl/spu_sub_arbiter.sv
// Round-robin arbiter sharing one pipelined subtractor between NUM_REQ requesters.
module spu_sub_arbiter
    import spu_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned LATENCY   = 1,
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned TAG_BITS  = $clog2(NUM_REQ)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         cke,
    input  logic [NUM_REQ-1:0]           s_valid,
    output logic [NUM_REQ-1:0]           s_ready,
    input  logic [NUM_REQ*DATA_BITS-1:0] s_data0,
    input  logic [NUM_REQ*DATA_BITS-1:0] s_data1,
    output logic [NUM_REQ-1:0]           m_valid,
    output logic [TAG_BITS-1:0]          m_tag,
    output logic [DATA_BITS-1:0]         m_data,
    output logic                         busy
);

    tag_t                  r_last_grant;
    logic [MAX_REQ-1:0]    w_valid_ext;
    rr_pick_t              w_pick;
    logic                  w_xfer;
    logic [TAG_BITS-1:0]   w_win;
    logic [TAG_BITS-1:0]   w_tag_in;
    logic [DATA_BITS-1:0]  w_opa;
    logic [DATA_BITS-1:0]  w_opb;
    logic                  w_out_valid;
    logic                  w_inflight;

    // Widen requests to the package scan width; unused upper bits stay clear.
    always_comb begin
        w_valid_ext              = '0;
        w_valid_ext[NUM_REQ-1:0] = s_valid;
    end

    assign w_pick   = rr_pick(w_valid_ext, r_last_grant, NUM_REQ);
    assign w_xfer   = w_pick.found & cke;
    assign w_win    = w_pick.idx[TAG_BITS-1:0];
    assign w_tag_in = w_xfer ? w_win : '0;

    // One-hot grant to the scan winner, suppressed while the clock enable is low.
    always_comb begin
        s_ready = '0;
        if (w_xfer) begin
            s_ready[w_win] = 1'b1;
        end
    end

    // Route the winner's operand pair into the shared subtractor.
    always_comb begin
        w_opa = '0;
        w_opb = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (w_win == TAG_BITS'(i)) begin
                w_opa = s_data0[i*DATA_BITS +: DATA_BITS];
                w_opb = s_data1[i*DATA_BITS +: DATA_BITS];
            end
        end
    end

    // Pointer moves only on a transfer; reset value gives requester 0 first priority.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last_grant <= tag_t'(NUM_REQ - 1);
        end else if (w_xfer) begin
            r_last_grant <= w_pick.idx;
        end
    end

    spu_sub #(
        .LATENCY   (LATENCY),
        .DATA_BITS (DATA_BITS)
    ) u_sub (
        .i_clk  (clk),
        .i_rst  (reset),
        .i_cke  (cke),
        .i_a    (w_opa),
        .i_b    (w_opb),
        .o_diff (m_data)
    );

    spu_data #(
        .LATENCY  (LATENCY),
        .TAG_BITS (TAG_BITS)
    ) u_tags (
        .i_clk      (clk),
        .i_rst      (reset),
        .i_cke      (cke),
        .i_valid    (w_xfer),
        .i_tag      (w_tag_in),
        .o_valid    (w_out_valid),
        .o_tag      (m_tag),
        .o_inflight (w_inflight)
    );

    // Decode the delayed tag into the per-requester result strobe.
    always_comb begin
        m_valid = '0;
        if (w_out_valid) begin
            m_valid[m_tag] = 1'b1;
        end
    end

    assign busy = (|s_valid) | w_inflight;

endmodule

// File: tb/tb_spu_sub_arbiter.sv
// Scoreboard bench: three builds (LATENCY 0, 1, 3) share one directed stimulus stream.
module tb_spu_sub_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        cke;
    logic [3:0]  s_valid;
    logic [31:0] s_data0;
    logic [31:0] s_data1;
    logic [31:0] D0 = '0;
    logic [31:0] D1 = '0;

    logic [3:0] rdy0, rdy1, rdy3, mv0, mv1, mv3;
    logic [1:0] tag0, tag1, tag3;
    logic [7:0] dat0, dat1, dat3;
    logic       busy0, busy1, busy3;

    typedef struct {
        logic [1:0]  tag;
        logic [7:0]  data;
        int unsigned due;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q3[$];
    exp_t e;

    int          checks = 0;
    int          errors = 0;
    int unsigned ecnt   = 0;
    logic        prev_en   = 1'b0;
    logic        prev_hold = 1'b0;
    logic [13:0] snap1 = '0;
    logic [13:0] snap3 = '0;

    always #5 clk = ~clk;

    spu_sub_arbiter #(.NUM_REQ(4), .LATENCY(0), .DATA_BITS(8)) u_dut0 (
        .clk(clk), .reset(reset), .cke(cke), .s_valid(s_valid), .s_ready(rdy0),
        .s_data0(s_data0), .s_data1(s_data1), .m_valid(mv0), .m_tag(tag0),
        .m_data(dat0), .busy(busy0));

    spu_sub_arbiter #(.NUM_REQ(4), .LATENCY(1), .DATA_BITS(8)) u_dut1 (
        .clk(clk), .reset(reset), .cke(cke), .s_valid(s_valid), .s_ready(rdy1),
        .s_data0(s_data0), .s_data1(s_data1), .m_valid(mv1), .m_tag(tag1),
        .m_data(dat1), .busy(busy1));

    spu_sub_arbiter #(.NUM_REQ(4), .LATENCY(3), .DATA_BITS(8)) u_dut3 (
        .clk(clk), .reset(reset), .cke(cke), .s_valid(s_valid), .s_ready(rdy3),
        .s_data0(s_data0), .s_data1(s_data1), .m_valid(mv3), .m_tag(tag3),
        .m_data(dat3), .busy(busy3));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp(input string inst, input exp_t x, input logic [3:0] mv,
                       input logic [1:0] tg, input logic [7:0] d);
        logic [3:0] oh;
        oh = 4'b0001 << x.tag;
        chk({inst, " m_valid"}, 32'(mv), 32'(oh));
        chk({inst, " m_tag"},   32'(tg), 32'(x.tag));
        chk({inst, " m_data"},  32'(d),  32'(x.data));
        chk({inst, " timing"},  ecnt,    x.due);
    endtask

    // Enabled-cycle counter and per-edge flags for the monitor.
    always @(posedge clk) begin
        prev_en   <= !reset && cke;
        prev_hold <= !reset && !cke;
        if (!reset && cke) ecnt <= ecnt + 1;
    end

    // Monitor: pop and compare whenever a build presents a fresh result.
    always @(negedge clk) begin
        if (!reset) begin
            if (cke && mv0 != 4'b0) begin
                if (q0.size() == 0) chk("L0 unexpected m_valid", 32'(mv0), 32'd0);
                else begin e = q0.pop_front(); cmp("L0", e, mv0, tag0, dat0); end
            end
            if (prev_en && mv1 != 4'b0) begin
                if (q1.size() == 0) chk("L1 unexpected m_valid", 32'(mv1), 32'd0);
                else begin e = q1.pop_front(); cmp("L1", e, mv1, tag1, dat1); end
            end
            if (prev_en && mv3 != 4'b0) begin
                if (q3.size() == 0) chk("L3 unexpected m_valid", 32'(mv3), 32'd0);
                else begin e = q3.pop_front(); cmp("L3", e, mv3, tag3, dat3); end
            end
            if (prev_hold) begin
                chk("L1 hold while cke=0", 32'({mv1, tag1, dat1}), 32'(snap1));
                chk("L3 hold while cke=0", 32'({mv3, tag3, dat3}), 32'(snap3));
            end
        end
        snap1 = {mv1, tag1, dat1};
        snap3 = {mv3, tag3, dat3};
    end

    task automatic set_data(input int i, input logic [7:0] a, input logic [7:0] b);
        D0[i*8 +: 8] = a;
        D1[i*8 +: 8] = b;
    endtask

    // One cycle of stimulus with the hand-computed grant and difference.
    task automatic step(input logic [3:0] v, input logic ck,
                        input logic [3:0] exp_rdy, input logic [7:0] exp_diff);
        logic [1:0] t;
        @(posedge clk);
        #1;
        s_valid = v;
        cke     = ck;
        s_data0 = D0;
        s_data1 = D1;
        #1;
        chk("s_ready L0", 32'(rdy0), 32'(exp_rdy));
        chk("s_ready L1", 32'(rdy1), 32'(exp_rdy));
        chk("s_ready L3", 32'(rdy3), 32'(exp_rdy));
        chk("busy L0",    32'(busy0), 32'(|v));
        if (exp_rdy != 4'b0) begin
            t = 2'd0;
            for (int i = 0; i < 4; i++) if (exp_rdy[i]) t = 2'(i);
            q0.push_back('{tag: t, data: exp_diff, due: ecnt});
            q1.push_back('{tag: t, data: exp_diff, due: ecnt + 1});
            q3.push_back('{tag: t, data: exp_diff, due: ecnt + 3});
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        reset   = 1'b1;
        cke     = 1'b1;
        s_valid = 4'b0;
        set_data(0, 8'd20,  8'd5);
        set_data(1, 8'd7,   8'd9);
        set_data(2, 8'd10,  8'd3);
        set_data(3, 8'd100, 8'hE4);
        s_data0 = D0;
        s_data1 = D1;
        #3;
        chk("reset m_valid L1", 32'(mv1), 32'd0);
        chk("reset m_valid L3", 32'(mv3), 32'd0);
        chk("reset m_tag L1",   32'(tag1), 32'd0);
        chk("reset m_data L1",  32'(dat1), 32'd0);
        chk("reset m_data L3",  32'(dat3), 32'd0);
        chk("reset busy L3",    32'(busy3), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Single requester 2 right after reset.
        step(4'b0100, 1'b1, 4'b0100, 8'd7);
        step(4'b0000, 1'b1, 4'b0000, 8'd0);
        step(4'b1000, 1'b1, 4'b1000, 8'h80);

        // All requesters: rotation 0,1,2,3,0,1,2,3.
        for (int r = 0; r < 2; r++) begin
            step(4'b1111, 1'b1, 4'b0001, 8'h0F);
            step(4'b1111, 1'b1, 4'b0010, 8'hFE);
            step(4'b1111, 1'b1, 4'b0100, 8'h07);
            step(4'b1111, 1'b1, 4'b1000, 8'h80);
        end

        // Wrap-around arithmetic; lone requester granted back to back.
        set_data(0, 8'h80, 8'd1);
        step(4'b0001, 1'b1, 4'b0001, 8'h7F);
        set_data(0, 8'd5, 8'd10);
        step(4'b0001, 1'b1, 4'b0001, 8'hFB);
        set_data(0, 8'd20, 8'd5);

        // Clock-enable pause in the middle of a stream.
        step(4'b1111, 1'b1, 4'b0010, 8'hFE);
        step(4'b1111, 1'b0, 4'b0000, 8'd0);
        step(4'b1111, 1'b0, 4'b0000, 8'd0);
        step(4'b1111, 1'b1, 4'b0100, 8'h07);
        step(4'b1111, 1'b1, 4'b1000, 8'h80);
        for (int k = 0; k < 4; k++) step(4'b0000, 1'b1, 4'b0000, 8'd0);

        // Reset with three results in flight on the LATENCY=3 build.
        step(4'b1111, 1'b1, 4'b0001, 8'h0F);
        step(4'b1111, 1'b1, 4'b0010, 8'hFE);
        step(4'b1111, 1'b1, 4'b0100, 8'h07);
        @(posedge clk);
        #1;
        reset   = 1'b1;
        s_valid = 4'b0;
        q0.delete();
        q1.delete();
        q3.delete();
        #1;
        chk("mid-reset m_valid L1", 32'(mv1), 32'd0);
        chk("mid-reset m_valid L3", 32'(mv3), 32'd0);
        chk("mid-reset busy L3",    32'(busy3), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        for (int k = 0; k < 3; k++) step(4'b0000, 1'b1, 4'b0000, 8'd0);
        step(4'b1111, 1'b1, 4'b0001, 8'h0F);
        for (int k = 0; k < 4; k++) step(4'b0000, 1'b1, 4'b0000, 8'd0);

        // Requester 1 alone: same-cycle result on the LATENCY=0 build.
        set_data(1, 8'd1, 8'd2);
        step(4'b0010, 1'b1, 4'b0010, 8'hFF);
        for (int k = 0; k < 5; k++) step(4'b0000, 1'b1, 4'b0000, 8'd0);

        chk("L0 results outstanding", q0.size(), 32'd0);
        chk("L1 results outstanding", q1.size(), 32'd0);
        chk("L3 results outstanding", q3.size(), 32'd0);
        chk("idle busy L3", 32'(busy3), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spu_sub_arbiter.md
Name: spu_sub_arbiter

Overview:
- Shares one pipelined subtract unit between NUM_REQ requesters.
- Round-robin arbitration grants at most one operand pair per enabled cycle.
- The grant tag travels alongside the datapath, so each result is returned to the requester that issued it.
- Sits between the stage-2 request sources and the subtract datapath.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- LATENCY, 1, subtract pipeline depth in enabled cycles (0..16). The tag/valid delay line uses the same depth.
- DATA_BITS, 8, width of both operands and the result; signed two's complement.
- TAG_BITS, $clog2(NUM_REQ), width of the requester index.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-high reset.
- cke  input  1  clock enable; all state holds while cke=0.
- s_valid  input  NUM_REQ  per-requester request valid.
- s_ready  output  NUM_REQ  per-requester grant; one-hot or zero.
- s_data0  input  NUM_REQ*DATA_BITS  minuends; requester i occupies slice [i*DATA_BITS +: DATA_BITS].
- s_data1  input  NUM_REQ*DATA_BITS  subtrahends, same slicing.
- m_valid  output  NUM_REQ  one-hot result strobe to the owning requester.
- m_tag  output  TAG_BITS  index of the result owner.
- m_data  output  DATA_BITS  result, shared by all requesters.
- busy  output  1  high while any result is in flight or any s_valid is high.

Behaviour:
- Reset (asynchronous assert): the round-robin pointer last_grant becomes NUM_REQ-1, so requester 0 has top priority first.
- Reset clears all tag-pipeline valids. m_valid=0, m_tag=0, m_data=0.
- Reset mid-operation discards in-flight results; none are delivered after release.
- Arbitration is combinational from s_valid, cke and last_grant:
  - Scan order is last_grant+1, last_grant+2, ... with wrap from NUM_REQ-1 to 0.
  - The first asserted s_valid wins; s_ready[winner]=1 only when cke=1. All other s_ready bits are 0.
  - If no request is pending, s_ready=0.
- Transfer occurs when s_valid[i] && s_ready[i]. On that cycle:
  - last_grant <= i.
  - Operands s_data0[i] and s_data1[i] enter the datapath.
  - A valid=1, tag=i entry enters the delay line.
- With no transfer in an enabled cycle, a valid=0 bubble enters the delay line; last_grant holds.
- Requesters must hold s_valid and their data stable until granted. Dropping s_valid before the grant is allowed and simply removes the request.
- Result timing:
  - A transfer in enabled cycle T produces m_valid[tag]=1, m_tag=tag and m_data=(data0-data1) mod 2^DATA_BITS exactly LATENCY enabled cycles later.
  - With LATENCY=0 the result appears combinationally in the same cycle.
- Arithmetic: DATA_BITS signed subtraction that wraps, with no saturation. Example: -128-1 = 127 at 8 bits.
- Throughput is one result per enabled cycle. There is no output backpressure: consumers must accept m_valid on every cycle it is asserted.
- m_data is don't-care when m_valid=0; the bench must not check it then.
- cke=0 freezes the delay line, last_grant and the outputs. s_ready is forced to 0 while cke=0.
- A single requester holding s_valid is granted every cycle.
- With all requesters asserted, grants rotate 0,1,2,...,NUM_REQ-1,0.
- busy is combinational: OR of s_valid, OR'd with any delay-line valid.

Decomposition:
- Shared package spu_arb_pkg holds:
  - tag type tag_t, sized by TAG_BITS.
  - a round-robin next-index function, rr_pick(valid, last), reused by other SPU arbiters.
- Sub-module spu_sub: instantiated once with LATENCY and DATA_BITS. It supplies the datapath and its internal delay.
- Sub-module spu_data: carries the valid+tag word through the same LATENCY so that valid, tag and data stay aligned by construction.
- The arbiter adds only the pointer register and the grant logic.

Test Plan:
- Reset release with only s_valid[2]=1, data0=10, data1=3, LATENCY=1 -> s_ready=0100 in cycle 0. Next cycle: m_valid=0100, m_tag=2, m_data=7.
- All four requesters held valid for 8 cycles -> grant order 0,1,2,3,0,1,2,3. Results arrive in the same order, each with the matching difference.
- Wrap case, 8-bit: data0=-128, data1=1 -> m_data=127. Then data0=5, data1=10 -> m_data=-5 (0xFB).
- cke toggled 1,0,0,1 during a stream (LATENCY=3) -> no grants and no output change while cke=0. Results are delayed by exactly 2 cycles and none are lost or duplicated.
- Reset asserted with 3 results in flight (LATENCY=3) -> m_valid=0 immediately, with no m_valid for 3 cycles after release. The first request after release goes to requester 0 when all requesters are valid.
- LATENCY=0 build, requester 1 only, data0=1, data1=2 -> same-cycle m_valid=0010, m_data=-1; busy tracks s_valid.
